// File: rtl/gpr_pkg.sv
// ---------------------------------------------------------------------------
// gpr_pkg
// Shared definitions for the GPR write-back stage:
//   - default register-bank geometry (data width, register count)
//   - default FIFO depth and starvation limit
//   - wb_entry_t : one pending register write (destination + data)
//   - wb_grant_t : which source owns the write port in a given cycle
// ---------------------------------------------------------------------------
package gpr_pkg;

    localparam int DEFAULT_DATA_W     = 16;
    localparam int DEFAULT_NREG       = 8;
    localparam int DEFAULT_ADDR_W     = $clog2(DEFAULT_NREG);
    localparam int DEFAULT_FIFO_DEPTH = 2;
    localparam int DEFAULT_STARVE_LIM = 4;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] rd;
        logic [DEFAULT_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_MEM  = 2'd1,
        GRANT_ALU  = 2'd2
    } wb_grant_t;

endpackage

// File: rtl/gpr_writeback_unit_if.sv
// ---------------------------------------------------------------------------
// gpr_writeback_unit_if
// Bundles the ALU-result and memory-load handshakes together with the
// register-bank write outputs of the write-back stage.
//   master : producer side (drives ALU/load requests, observes outputs)
//   slave  : the write-back unit itself
// Signals:
//   alu_valid/alu_ready/alu_rd/alu_data  ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data  load data handshake
//   gpr_write   one-hot write strobe, bit i drives register i
//   gpr_data    shared write data
//   fifo_count  ALU buffer occupancy
//   busy        buffer non-empty or a write in flight
// ---------------------------------------------------------------------------
interface gpr_writeback_unit_if #(
    parameter int DATA_W = gpr_pkg::DEFAULT_DATA_W,
    parameter int NREG   = gpr_pkg::DEFAULT_NREG,
    parameter int ADDR_W = $clog2(NREG)
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;

    logic [NREG-1:0]   gpr_write;
    logic [DATA_W-1:0] gpr_data;
    logic [ADDR_W:0]   fifo_count;
    logic              busy;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready,
        input  gpr_write, gpr_data, fifo_count, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready,
        output gpr_write, gpr_data, fifo_count, busy
    );

endinterface

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small circular buffer holding pending ALU results. The head entry is read
// combinationally so a push at one edge can be popped at the very next edge.
// Ports:
//   clk, rst     clock, asynchronous active-low reset (clears pointers/count)
//   push         write push_entry at the tail (ignored when full)
//   push_entry   entry to write
//   pop          discard the head (ignored when empty)
//   head         current head entry
//   count        occupancy
//   full, empty  occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module wb_fifo #(
    parameter int  DEPTH   = gpr_pkg::DEFAULT_FIFO_DEPTH,
    parameter type entry_t = gpr_pkg::wb_entry_t,
    parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t             mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    // Storage has no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/gpr_writeback_unit.sv
// ---------------------------------------------------------------------------
// gpr_writeback_unit
// Write-back stage merging ALU results and memory loads into a bank of
// general purpose registers. ALU results are buffered in wb_fifo; loads win
// arbitration unless the ALU has lost STARVE_LIM times in a row while
// holding a buffered result, in which case the ALU is forced through and
// mem_ready drops for that cycle.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   wb         gpr_writeback_unit_if.slave (handshakes + register outputs)
//   rs_addr    forwarding lookup address            (WB_FWD_EN only)
//   fwd_hit    a write to rs_addr is on the strobes (WB_FWD_EN only)
//   fwd_data   forwarded data, 0 when no hit        (WB_FWD_EN only)
// Build option: define WB_FWD_EN to add the forwarding ports and logic.
// ---------------------------------------------------------------------------
module gpr_writeback_unit
    import gpr_pkg::*;
#(
    parameter int DATA_W     = gpr_pkg::DEFAULT_DATA_W,
    parameter int NREG       = gpr_pkg::DEFAULT_NREG,
    parameter int FIFO_DEPTH = gpr_pkg::DEFAULT_FIFO_DEPTH,
    parameter int STARVE_LIM = gpr_pkg::DEFAULT_STARVE_LIM,
    parameter int ADDR_W     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    gpr_writeback_unit_if.slave wb
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]   rs_addr,
    output logic                fwd_hit,
    output logic [DATA_W-1:0]   fwd_data
`endif
);

    localparam int SCNT_W = $clog2(STARVE_LIM + 1);
    localparam int CNT_W  = ADDR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    // FIFO side
    entry_t             push_entry;
    entry_t             head_entry;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt;

    // Arbitration
    wb_grant_t          grant;
    entry_t             sel_entry;
    logic               force_alu;
    logic [SCNT_W-1:0]  starve_reg;
    logic [SCNT_W-1:0]  starve_next;

    // Output stage
    logic [NREG-1:0]    write_next;
    logic [NREG-1:0]    gpr_write_reg;
    logic [DATA_W-1:0]  gpr_data_reg;

    assign push_entry = '{rd: wb.alu_rd, data: wb.alu_data};

    // Readiness depends only on occupancy: a same-cycle pop never frees a
    // full slot. Gated by rst so nothing is accepted during reset.
    assign wb.alu_ready = rst && !fifo_full;
    assign fifo_push    = wb.alu_valid && wb.alu_ready;

    assign force_alu    = (starve_reg == SCNT_W'(STARVE_LIM));
    assign wb.mem_ready = !force_alu;

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head_entry),
        .count      (fifo_cnt),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // One grant per cycle: forced ALU, then load, then buffered ALU.
    always_comb begin
        grant     = GRANT_NONE;
        sel_entry = '0;
        if (force_alu) begin
            // The counter only reaches the limit with a result buffered,
            // so the FIFO cannot be empty here; guard anyway.
            if (!fifo_empty) begin
                grant     = GRANT_ALU;
                sel_entry = head_entry;
            end
        end else if (wb.mem_valid) begin
            grant     = GRANT_MEM;
            sel_entry = '{rd: wb.mem_rd, data: wb.mem_data};
        end else if (!fifo_empty) begin
            grant     = GRANT_ALU;
            sel_entry = head_entry;
        end
    end

    assign fifo_pop = (grant == GRANT_ALU);

    // Count consecutive lost arbitrations while a result is waiting.
    always_comb begin
        starve_next = starve_reg;
        if (fifo_pop) begin
            starve_next = '0;
        end else if ((grant == GRANT_MEM) && !fifo_empty && !force_alu) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    // One-hot decode; a destination >= NREG matches no bit, so the entry is
    // consumed but produces no strobe.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_decode
            assign write_next[gi] = (grant != GRANT_NONE) &&
                                    (sel_entry.rd == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpr_write_reg <= '0;
            gpr_data_reg  <= '0;
            starve_reg    <= '0;
        end else begin
            gpr_write_reg <= write_next;
            starve_reg    <= starve_next;
            // Data holds across idle cycles and dropped writes.
            if (|write_next) begin
                gpr_data_reg <= sel_entry.data;
            end
        end
    end

    assign wb.gpr_write  = gpr_write_reg;
    assign wb.gpr_data   = gpr_data_reg;
    assign wb.fifo_count = fifo_cnt;
    assign wb.busy       = (fifo_cnt != '0) || (gpr_write_reg != '0);

`ifdef WB_FWD_EN
    // Forward the write currently on the strobes to a same-cycle reader.
    assign fwd_hit  = gpr_write_reg[rs_addr];
    assign fwd_data = fwd_hit ? gpr_data_reg : '0;
`endif

endmodule

// File: tb/tb_gpr_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_gpr_writeback_unit
// Directed self-checking bench for gpr_writeback_unit. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_gpr_writeback_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

`ifdef WB_FWD_EN
    logic [2:0]  rs_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    gpr_writeback_unit_if #(.DATA_W(16), .NREG(8)) wb_if ();

    gpr_writeback_unit #(
        .DATA_W     (16),
        .NREG       (8),
        .FIFO_DEPTH (2),
        .STARVE_LIM (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (wb_if.slave)
`ifdef WB_FWD_EN
        ,
        .rs_addr  (rs_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        wb_if.alu_valid = 1'b0;
        wb_if.alu_rd    = '0;
        wb_if.alu_data  = '0;
        wb_if.mem_valid = 1'b0;
        wb_if.mem_rd    = '0;
        wb_if.mem_data  = '0;
`ifdef WB_FWD_EN
        rs_addr = 3'd0;
`endif

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_gpr_write", 32'(wb_if.gpr_write), 32'h00);
        check("rst_gpr_data", 32'(wb_if.gpr_data), 32'h0000);
        check("rst_fifo_count", 32'(wb_if.fifo_count), 32'd0);
        check("rst_busy", 32'(wb_if.busy), 32'd0);
        check("rst_alu_ready", 32'(wb_if.alu_ready), 32'd0);
        check("rst_mem_ready", 32'(wb_if.mem_ready), 32'd1);
        rst = 1'b1;
        tick();
        check("alu_ready_up", 32'(wb_if.alu_ready), 32'd1);

        // ---------------- single ALU push ----------------
        wb_if.alu_valid = 1'b1;
        wb_if.alu_rd    = 3'd3;
        wb_if.alu_data  = 16'h2445;
        tick();                                   // push edge
        wb_if.alu_valid = 1'b0;
        check("alu1_wr_e0", 32'(wb_if.gpr_write), 32'h00);
        check("alu1_cnt_e0", 32'(wb_if.fifo_count), 32'd1);
        tick();                                   // pop edge
        check("alu1_wr_e1", 32'(wb_if.gpr_write), 32'h08);
        check("alu1_data_e1", 32'(wb_if.gpr_data), 32'h2445);
        check("alu1_busy_e1", 32'(wb_if.busy), 32'd1);
        check("alu1_cnt_e1", 32'(wb_if.fifo_count), 32'd0);
        tick();
        check("alu1_wr_e2", 32'(wb_if.gpr_write), 32'h00);
        check("alu1_hold_data", 32'(wb_if.gpr_data), 32'h2445);
        check("alu1_busy_e2", 32'(wb_if.busy), 32'd0);

        // ---------------- simultaneous load and ALU ----------------
        wb_if.alu_valid = 1'b1;
        wb_if.alu_rd    = 3'd2;
        wb_if.alu_data  = 16'h0001;
        wb_if.mem_valid = 1'b1;
        wb_if.mem_rd    = 3'd1;
        wb_if.mem_data  = 16'hE5C5;
        tick();
        wb_if.alu_valid = 1'b0;
        wb_if.mem_valid = 1'b0;
        check("both_mem_wr", 32'(wb_if.gpr_write), 32'h02);
        check("both_mem_data", 32'(wb_if.gpr_data), 32'hE5C5);
        check("both_cnt", 32'(wb_if.fifo_count), 32'd1);
        tick();
        check("both_alu_wr", 32'(wb_if.gpr_write), 32'h04);
        check("both_alu_data", 32'(wb_if.gpr_data), 32'h0001);
        tick();
        check("both_idle", 32'(wb_if.gpr_write), 32'h00);

        // ---------------- starvation guard ----------------
        wb_if.alu_valid = 1'b1;
        wb_if.alu_rd    = 3'd6;
        wb_if.alu_data  = 16'h1234;
        wb_if.mem_valid = 1'b1;
        wb_if.mem_rd    = 3'd0;
        wb_if.mem_data  = 16'hA000;
        check("stv_mem_ready0", 32'(wb_if.mem_ready), 32'd1);
        tick();                                   // push + load, counter stays 0
        wb_if.alu_valid = 1'b0;
        check("stv_wr0", 32'(wb_if.gpr_write), 32'h01);
        for (int k = 1; k <= 4; k++) begin
            wb_if.mem_data = 16'hA000 + 16'(k);
            tick();                               // load wins, counter = k
            check($sformatf("stv_wr%0d", k), 32'(wb_if.gpr_write), 32'h01);
            check($sformatf("stv_data%0d", k), 32'(wb_if.gpr_data), 32'hA000 + k);
            check($sformatf("stv_mready%0d", k), 32'(wb_if.mem_ready), (k < 4) ? 32'd1 : 32'd0);
        end
        wb_if.mem_data = 16'hA005;
        tick();                                   // forced ALU pop
        check("stv_forced_wr", 32'(wb_if.gpr_write), 32'h40);
        check("stv_forced_data", 32'(wb_if.gpr_data), 32'h1234);
        check("stv_mready_back", 32'(wb_if.mem_ready), 32'd1);
        check("stv_cnt_empty", 32'(wb_if.fifo_count), 32'd0);
        for (int k = 6; k <= 9; k++) begin
            wb_if.mem_data = 16'hA000 + 16'(k);
            tick();
            check($sformatf("stv_tail_wr%0d", k), 32'(wb_if.gpr_write), 32'h01);
            check($sformatf("stv_tail_rdy%0d", k), 32'(wb_if.mem_ready), 32'd1);
        end
        wb_if.mem_valid = 1'b0;
        tick();
        check("stv_idle", 32'(wb_if.gpr_write), 32'h00);

        // ---------------- FIFO full with loads running ----------------
        wb_if.mem_valid = 1'b1;
        wb_if.mem_rd    = 3'd7;
        wb_if.mem_data  = 16'h7777;
        wb_if.alu_valid = 1'b1;
        wb_if.alu_rd    = 3'd1;
        wb_if.alu_data  = 16'h1111;
        tick();                                   // push 1
        wb_if.alu_rd   = 3'd2;
        wb_if.alu_data = 16'h2222;
        tick();                                   // push 2, counter 1
        wb_if.alu_rd   = 3'd3;
        wb_if.alu_data = 16'h3333;
        check("full_cnt", 32'(wb_if.fifo_count), 32'd2);
        check("full_alu_ready", 32'(wb_if.alu_ready), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            tick();                               // counter k, third result held off
            check($sformatf("full_cnt_e%0d", k), 32'(wb_if.fifo_count), 32'd2);
            check($sformatf("full_ardy_e%0d", k), 32'(wb_if.alu_ready), 32'd0);
        end
        check("full_mready_low", 32'(wb_if.mem_ready), 32'd0);
        tick();                                   // forced pop of rd=1
        check("full_pop_wr", 32'(wb_if.gpr_write), 32'h02);
        check("full_pop_cnt", 32'(wb_if.fifo_count), 32'd1);
        check("full_pop_ardy", 32'(wb_if.alu_ready), 32'd1);
        tick();                                   // third push accepted, load wins
        wb_if.alu_valid = 1'b0;
        wb_if.mem_valid = 1'b0;
        check("full_push3_cnt", 32'(wb_if.fifo_count), 32'd2);
        check("full_push3_wr", 32'(wb_if.gpr_write), 32'h80);
        tick();
        check("drain_wr_rd2", 32'(wb_if.gpr_write), 32'h04);
        check("drain_data_rd2", 32'(wb_if.gpr_data), 32'h2222);
        tick();
        check("drain_wr_rd3", 32'(wb_if.gpr_write), 32'h08);
        check("drain_data_rd3", 32'(wb_if.gpr_data), 32'h3333);
        tick();
        check("drain_idle", 32'(wb_if.gpr_write), 32'h00);
        check("drain_busy", 32'(wb_if.busy), 32'd0);

        // ---------------- reset mid-operation ----------------
        wb_if.mem_valid = 1'b1;
        wb_if.mem_rd    = 3'd0;
        wb_if.mem_data  = 16'h5A5A;
        wb_if.alu_valid = 1'b1;
        wb_if.alu_rd    = 3'd4;
        wb_if.alu_data  = 16'h4444;
        tick();
        wb_if.alu_rd   = 3'd5;
        wb_if.alu_data = 16'h5555;
        tick();
        wb_if.alu_valid = 1'b0;
        wb_if.mem_valid = 1'b0;
        check("prerst_cnt", 32'(wb_if.fifo_count), 32'd2);
        check("prerst_busy", 32'(wb_if.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_wr", 32'(wb_if.gpr_write), 32'h00);
        check("midrst_cnt", 32'(wb_if.fifo_count), 32'd0);
        check("midrst_busy", 32'(wb_if.busy), 32'd0);
        check("midrst_ardy", 32'(wb_if.alu_ready), 32'd0);
        check("midrst_mrdy", 32'(wb_if.mem_ready), 32'd1);
        tick();
        check("inrst_wr", 32'(wb_if.gpr_write), 32'h00);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("postrst_wr%0d", k), 32'(wb_if.gpr_write), 32'h00);
            check($sformatf("postrst_cnt%0d", k), 32'(wb_if.fifo_count), 32'd0);
        end

`ifdef WB_FWD_EN
        // ---------------- forwarding ----------------
        rs_addr         = 3'd5;
        wb_if.alu_valid = 1'b1;
        wb_if.alu_rd    = 3'd5;
        wb_if.alu_data  = 16'h00FF;
        tick();                                   // push
        wb_if.alu_valid = 1'b0;
        check("fwd_miss_pre", 32'(fwd_hit), 32'd0);
        check("fwd_data_pre", 32'(fwd_data), 32'h0000);
        tick();                                   // write to r5 on the strobes
        check("fwd_hit", 32'(fwd_hit), 32'd1);
        check("fwd_data", 32'(fwd_data), 32'h00FF);
        rs_addr = 3'd4;
        #1;
        check("fwd_other_hit", 32'(fwd_hit), 32'd0);
        check("fwd_other_data", 32'(fwd_data), 32'h0000);
        rs_addr = 3'd5;
        tick();
        check("fwd_miss_post", 32'(fwd_hit), 32'd0);
        check("fwd_data_post", 32'(fwd_data), 32'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_writeback_unit.md
# gpr_writeback_unit

Write-back stage that merges ALU results and memory-load data into the per-core bank of 16-bit general purpose registers. It produces the one-hot write strobes and shared write data that drive the `write`/`data_in` pins of each register instance. ALU results are buffered in a small FIFO. Memory loads have priority, and a starvation guard prevents ALU results from being held off indefinitely.

## Interface
- DATA_W, 16, register data width
- NREG, 8, number of registers in the bank; ADDR_W = $clog2(NREG) is derived
- FIFO_DEPTH, 2, ALU result buffer entries (power of two, >= 2)
- STARVE_LIM, 4, consecutive lost arbitrations before the ALU is forced to win

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result available
- alu_ready  out  1  FIFO can accept a result
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load data available
- mem_ready  out  1  load accepted this cycle
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- gpr_write  out  NREG  one-hot write strobe, bit i drives register i
- gpr_data  out  DATA_W  shared write data for all registers
- fifo_count  out  ADDR_W+1  current FIFO occupancy (width covers FIFO_DEPTH)
- busy  out  1  FIFO non-empty or a write is in flight

## Operation
- ALU push: occurs when alu_valid && alu_ready. alu_ready = (fifo_count < FIFO_DEPTH) and is 0 while rst is low. A pop in the same cycle does not free a full slot, so alu_ready does not depend on the pop.
- Memory transfer: occurs when mem_valid && mem_ready. mem_ready = !force_alu.
- Arbitration, once per cycle:
  - force_alu = 1: pop the FIFO head.
  - else mem_valid = 1: take the load.
  - else FIFO non-empty: pop the head.
  - else idle.
- Starvation counter: increments, saturating at STARVE_LIM, each cycle the FIFO is non-empty and the load wins. It clears on any pop. force_alu = (count == STARVE_LIM).
- Selected entry is registered into gpr_write/gpr_data:
  - gpr_write = one-hot of rd.
  - rd >= NREG: the write is dropped (gpr_write all zero) but the entry is still consumed.
- Idle cycle: gpr_write = 0 and gpr_data holds its last value.
- FIFO is circular, with rd/wr pointers wrapping modulo FIFO_DEPTH. Simultaneous push and pop leave the count unchanged.
- busy = (fifo_count != 0) || (gpr_write != 0).

## Timing
- Reset values: gpr_write = 0, gpr_data = 0, fifo_count = 0, busy = 0, alu_ready = 0 while rst is low, mem_ready = 1, starvation counter = 0, pointers = 0.
- Reset asserted mid-operation: buffered entries are discarded. No write strobe is issued after reset asserts.
- Load latency: a transfer at edge E makes gpr_write active in the cycle after E. The register captures at E+1.
- ALU latency with no competing load: a push at edge E is popped at E+1, gpr_write is active after E+1, and the register captures at E+2.
- gpr_write is asserted for exactly one cycle per accepted entry.
- Back-to-back writes to the same rd retire in acceptance order. Between the two sources, the entry issued later wins.

## Configuration
- WB_FWD_EN defined: adds ports
  - rs_addr in ADDR_W
  - fwd_hit out 1
  - fwd_data out DATA_W
- Forwarding behaviour: fwd_hit = 1 when gpr_write[rs_addr] is high. fwd_data = gpr_data in that case, else 0. Both are combinational from the registered outputs.
- WB_FWD_EN undefined: these ports and the logic behind them are absent. All other behaviour is identical.

## Structure
- Shared package `gpr_pkg`: DATA_W and NREG defaults, and a `wb_entry_t` struct holding rd and data.
- One sub-module, `wb_fifo`, parameterised by depth and entry type. It provides push/pop, count, full and empty.
- Arbitration, the starvation counter, one-hot decode and output registers sit in the top module.

## Test plan
- Reset, then single ALU push rd=3, data=16'h2445 → gpr_write=8'b0000_1000 and gpr_data=16'h2445 exactly 2 cycles after the handshake, for one cycle.
- mem_valid and alu_valid together (rd=1 data=16'hE5C5, rd=2 data=16'h0001) → load is written first (gpr_write=8'b0000_0010), ALU result on the next cycle (8'b0000_0100).
- mem_valid held high for 10 cycles with one ALU entry queued → mem_ready drops after 4 lost arbitrations, the ALU entry is written on the 5th, then mem_ready returns to 1.
- Fill the FIFO (2 pushes) with mem_valid high → alu_ready=0 and fifo_count=2. A third alu_valid is not accepted until a pop occurs.
- Push 2 entries, then assert rst low for 1 cycle → gpr_write stays 0, fifo_count=0, busy=0. No stale write appears after reset releases.
- WB_FWD_EN build: rs_addr=5 while a write to rd=5 with 16'h00FF is in flight → fwd_hit=1 and fwd_data=16'h00FF in that cycle. fwd_hit=0 otherwise.
